multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multi-cycle RV32-style datapath. Sequences
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per instruction.
// Produces memory strobes, IR/PC load strobes, datapath decode controls,
// a retire pulse and a 32-bit retired-instruction counter.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : an illegal opcode in DECODE parks the FSM in TRAP until reset
//   undefined : an illegal opcode retires in DECODE as a NOP; trap tied 0
//
// state | meaning
// ------+------------------------------------------------------------
// 0     | FETCH  : memory read of next instruction, IR load on mem_ready
// 1     | DECODE : opcode captured into op_q, legality check
// 2     | EXEC   : ALU cycle; branches retire here
// 3     | MEM    : load/store access, waits on mem_ready; stores retire
// 4     | WB     : register writeback and retire
// 5     | TRAP   : illegal opcode seen, all strobes idle, exit by reset only
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   Opcode[6:0]           instruction[6:0], valid from DECODE onward
//   mem_ready             current mem_req access completes this cycle
//   branch_taken          ALU branch result (datapath uses it for PC mux)
//   state[2:0]            current FSM state (encoding above)
//   mem_req, mem_we       memory request / write enable
//   ir_write, pc_write    IR load / PC load
//   retire                one-cycle instruction-complete pulse
//   RegWrite, MemtoReg    register file write / load-data writeback select
//   ALUsrcA, ALUsrcB      ALU operand selects
//   Jal, Jalr, Branch     control-flow class of the current instruction
//   writeSelect[1:0]      writeback source
//   ALUOp[1:0]            ALU operation class
//   trap                  sticky illegal-opcode flag
//   instret[31:0]         retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  Opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        retire,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        ALUsrcA,
    output logic        ALUsrcB,
    output logic        Jal,
    output logic        Jalr,
    output logic        Branch,
    output logic [1:0]  writeSelect,
    output logic [1:0]  ALUOp,
    output logic        trap,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [31:0] instret_q, instret_d;
    // Clears on reset and sets on the first edge after release, so the
    // first memory request starts one clock after reset is removed.
    logic        started_q;

    // The PC source choice (target vs PC+4) is made in the datapath from
    // Branch and branch_taken; the controller loads the PC either way.
    logic        unused_branch_taken;
    assign unused_branch_taken = branch_taken;

    logic is_r, is_lw, is_sw, is_i, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic is_legal, decode_active;

    // op_d is Opcode during DECODE (the value being captured) and op_q
    // afterwards, so decode controls are valid from DECODE and stay frozen
    // even if the instruction bus moves on.
    always_comb begin
        op_d = (state_q == ST_DECODE) ? Opcode : op_q;
    end

    always_comb begin
        is_r     = (op_d == OP_R);
        is_lw    = (op_d == OP_LW);
        is_sw    = (op_d == OP_SW);
        is_i     = (op_d == OP_I);
        is_br    = (op_d == OP_BR);
        is_jal   = (op_d == OP_JAL);
        is_jalr  = (op_d == OP_JALR);
        is_lui   = (op_d == OP_LUI);
        is_auipc = (op_d == OP_AUIPC);
        is_legal = is_r | is_lw | is_sw | is_i | is_br | is_jal | is_jalr |
                   is_lui | is_auipc;
        decode_active = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                        (state_q == ST_MEM)    || (state_q == ST_WB);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            op_q      <= 7'd0;
            instret_q <= 32'd0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            instret_q <= instret_d;
            started_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (started_q && mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_legal) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_EXEC: begin
                if (is_br)              state_d = ST_FETCH;
                else if (is_lw || is_sw) state_d = ST_MEM;
                else                    state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready) state_d = is_sw ? ST_FETCH : ST_WB;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        retire      = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        trap        = 1'b0;
        ALUsrcA     = 1'b0;
        ALUsrcB     = 1'b0;
        Jal         = 1'b0;
        Jalr        = 1'b0;
        Branch      = 1'b0;
        writeSelect = 2'b00;
        ALUOp       = 2'b00;

        case (state_q)
            ST_FETCH: begin
                mem_req  = started_q;
                ir_write = started_q & mem_ready;
            end
            ST_DECODE: begin
`ifndef CTRL_ILLEGAL_TRAP_EN
                // Illegal opcode retires as a NOP straight out of DECODE.
                if (!is_legal) begin
                    retire   = 1'b1;
                    pc_write = 1'b1;
                end
`endif
            end
            ST_EXEC: begin
                if (is_br) begin
                    retire   = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                if (mem_ready && is_sw) begin
                    retire   = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemtoReg = is_lw;
                retire   = 1'b1;
                pc_write = 1'b1;
            end
            ST_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                trap = 1'b1;
`endif
            end
            default: begin
            end
        endcase

        if (decode_active) begin
            ALUsrcA     = is_jal | is_lui | is_auipc;
            ALUsrcB     = is_lw | is_sw | is_i | is_jalr;
            writeSelect = {is_lui | is_auipc, is_jal | is_jalr | is_auipc};
            ALUOp       = {is_br | is_r | is_jal, is_br | is_jal | is_i};
            Jal         = is_jal;
            Jalr        = is_jalr;
            Branch      = is_br;
        end
    end

    always_comb begin
        instret_d = retire ? (instret_q + 32'd1) : instret_q;
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // strobe bundle bits: {mem_req, mem_we, ir_write, pc_write, retire, RegWrite, MemtoReg}
    localparam logic [6:0] SB_MREQ = 7'b1000000;
    localparam logic [6:0] SB_MWE  = 7'b0100000;
    localparam logic [6:0] SB_IRW  = 7'b0010000;
    localparam logic [6:0] SB_PCW  = 7'b0001000;
    localparam logic [6:0] SB_RET  = 7'b0000100;
    localparam logic [6:0] SB_RW   = 7'b0000010;
    localparam logic [6:0] SB_M2R  = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  Opcode = 7'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [2:0]  state;
    logic        mem_req, mem_we, ir_write, pc_write, retire;
    logic        RegWrite, MemtoReg, ALUsrcA, ALUsrcB, Jal, Jalr, Branch;
    logic [1:0]  writeSelect, ALUOp;
    logic        trap;
    logic [31:0] instret;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .state(state), .mem_req(mem_req),
        .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .retire(retire), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .Jal(Jal), .Jalr(Jalr),
        .Branch(Branch), .writeSelect(writeSelect), .ALUOp(ALUOp),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    logic [6:0] sb_dut;
    logic [8:0] dec_dut;
    assign sb_dut  = {mem_req, mem_we, ir_write, pc_write, retire, RegWrite, MemtoReg};
    assign dec_dut = {ALUsrcA, ALUsrcB, writeSelect, ALUOp, Jal, Jalr, Branch};

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_instret = 32'd0;

    typedef struct {
        logic [2:0] st;
        logic [6:0] sb;
        logic       mr;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        int         lat;
        logic [8:0] dec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_I) ||
               (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR) ||
               (op == OP_LUI) || (op == OP_AUIPC);
    endfunction

    // decode bundle {ALUsrcA, ALUsrcB, writeSelect, ALUOp, Jal, Jalr, Branch}
    function automatic logic [8:0] ref_dec(input logic [6:0] op);
        logic r, lw, sw, i, br, jal, jalr, lui, auipc;
        r = (op == OP_R); lw = (op == OP_LW); sw = (op == OP_SW); i = (op == OP_I);
        br = (op == OP_BR); jal = (op == OP_JAL); jalr = (op == OP_JALR);
        lui = (op == OP_LUI); auipc = (op == OP_AUIPC);
        return {jal | lui | auipc, lw | sw | i | jalr, lui | auipc, jal | jalr | auipc,
                br | r | jal, br | jal | i, jal, jalr, br};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        Opcode = 7'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'(sb_dut), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle_mreq", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        m_instret = 32'd0;
    endtask

    // Builds the expected per-cycle behaviour of one instruction from its class
    // and the memory wait lengths, drives it, and compares every cycle.
    task automatic run_instr(input logic [6:0] op, input int w_f, input int w_m,
                             input logic bt, output int lat);
        cyc_t q[$];
        cyc_t e;
        logic lw, sw, br;
        lw = (op == OP_LW); sw = (op == OP_SW); br = (op == OP_BR);
        for (int k = 0; k < w_f; k++) q.push_back('{3'd0, SB_MREQ, 1'b0});
        q.push_back('{3'd0, SB_MREQ | SB_IRW, 1'b1});
        if (!is_legal(op)) begin
            q.push_back('{3'd1, SB_PCW | SB_RET, 1'($urandom)});
        end else begin
            q.push_back('{3'd1, 7'd0, 1'($urandom)});
            q.push_back('{3'd2, br ? (SB_PCW | SB_RET) : 7'd0, 1'($urandom)});
            if (lw || sw) begin
                for (int k = 0; k < w_m; k++)
                    q.push_back('{3'd3, SB_MREQ | (sw ? SB_MWE : 7'd0), 1'b0});
                q.push_back('{3'd3, SB_MREQ | (sw ? (SB_MWE | SB_PCW | SB_RET) : 7'd0), 1'b1});
            end
            if (!br && !sw)
                q.push_back('{3'd4, SB_RW | SB_PCW | SB_RET | (lw ? SB_M2R : 7'd0), 1'($urandom)});
        end
        lat = 0;
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            mem_ready = e.mr;
            Opcode = (e.st == 3'd1) ? op : 7'($urandom);
            branch_taken = (e.st == 3'd2) ? bt : 1'($urandom);
            @(negedge clk);
            check("state", 32'(state), 32'(e.st));
            check("strobes", 32'(sb_dut), 32'(e.sb));
            check("decode", 32'(dec_dut),
                  32'((e.st >= 3'd1 && e.st <= 3'd4) ? ref_dec(op) : 9'd0));
            check("trap", 32'(trap), 32'd0);
            check("instret", instret, m_instret);
            if (retire && lat == 0) lat = i + 1;
            if ((e.sb & SB_RET) != 7'd0) m_instret = m_instret + 32'd1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[9];
        logic [6:0] legal_ops[9];
        logic [6:0] illegal_ops[4];
        logic [6:0] op;
        logic [8:0] got_dec;
        int         lat, cnt, idx;
        logic       done;

        tbl[0] = '{OP_R,     4, 9'b0_0_00_10_000};
        tbl[1] = '{OP_LW,    5, 9'b0_1_00_00_000};
        tbl[2] = '{OP_SW,    4, 9'b0_1_00_00_000};
        tbl[3] = '{OP_I,     4, 9'b0_1_00_01_000};
        tbl[4] = '{OP_BR,    3, 9'b0_0_00_11_001};
        tbl[5] = '{OP_JAL,   4, 9'b1_0_01_11_100};
        tbl[6] = '{OP_JALR,  4, 9'b0_1_01_00_010};
        tbl[7] = '{OP_LUI,   4, 9'b1_0_10_00_000};
        tbl[8] = '{OP_AUIPC, 4, 9'b1_0_11_00_000};
        for (int i = 0; i < 9; i++) legal_ops[i] = tbl[i].op;
        illegal_ops[0] = 7'b0000000; illegal_ops[1] = 7'b1111111;
        illegal_ops[2] = 7'b0001111; illegal_ops[3] = 7'b1110011;

        do_reset();

        // R-type single instruction from reset
        run_instr(OP_R, 0, 0, 1'b0, lat);
        check("r_latency", 32'(lat), 32'd4);
        check("r_instret", instret, 32'd1);
        check("r_back_fetch", 32'(state), 32'd0);

        // Latency/decode table with mem_ready tied high
        for (int t = 0; t < 9; t++) begin
            mem_ready = 1'b1;
            Opcode = tbl[t].op;
            branch_taken = 1'($urandom);
            cnt = 0; got_dec = 9'd0; done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge clk);
                cnt++;
                if (state == 3'd2) got_dec = dec_dut;
                if (retire) done = 1'b1;
                @(posedge clk); #1;
            end
            check("tbl_latency", 32'(cnt), 32'(tbl[t].lat));
            check("tbl_decode", 32'(got_dec), 32'(tbl[t].dec));
            check("tbl_instret", instret, m_instret + 32'd1);
            m_instret = m_instret + 32'd1;
        end

        // Two branches, taken then not taken
        do_reset();
        run_instr(OP_BR, 0, 0, 1'b1, lat);
        check("br_taken_latency", 32'(lat), 32'd3);
        run_instr(OP_BR, 0, 0, 1'b0, lat);
        check("br_not_taken_latency", 32'(lat), 32'd3);
        check("br_instret", instret, 32'd2);

        // Load with three wait cycles in MEM
        run_instr(OP_LW, 0, 3, 1'b0, lat);
        check("lw_wait_latency", 32'(lat), 32'd8);

        // Illegal opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
        mem_ready = 1'b1;
        Opcode = 7'($urandom);
        @(posedge clk); #1;
        Opcode = 7'b0000000;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            Opcode = 7'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
            check("trap_state", 32'(state), 32'd5);
            check("trap_flag", 32'(trap), 32'd1);
            check("trap_strobes", 32'(sb_dut), 32'd0);
            check("trap_instret", instret, m_instret);
            @(posedge clk); #1;
        end
        do_reset();
`else
        run_instr(7'b0000000, 0, 0, 1'b0, lat);
        check("nop_latency", 32'(lat), 32'd2);
        check("nop_back_fetch", 32'(state), 32'd0);
`endif

        // Reset in the middle of a memory wait
        run_instr(OP_SW, 1, 2, 1'b0, lat);
        Opcode = OP_LW;
        mem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (state == 3'd3) break;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_mem_state", 32'(state), 32'd3);
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_instret", instret, 32'd0);
        check("async_rst_strobes", 32'(sb_dut), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_idle_mem_req", 32'(mem_req), 32'd0);
        check("rel_idle_ir_write", 32'(ir_write), 32'd0);
        @(posedge clk); #1;
        m_instret = 32'd0;

        // instret wrap
        mem_ready = 1'b0;
        @(negedge clk);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        run_instr(OP_I, 0, 0, 1'b0, lat);
        check("instret_wrap", instret, 32'd0);

        // Randomised instruction stream
        for (int n = 0; n < 150; n++) begin
            idx = int'($urandom_range(0, 9));
`ifdef CTRL_ILLEGAL_TRAP_EN
            op = (idx < 9) ? legal_ops[idx] : legal_ops[0];
`else
            op = (idx < 9) ? legal_ops[idx] : illegal_ops[int'($urandom_range(0, 3))];
`endif
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
